// File: rtl/mask_result_collector.sv
// Frame capture RAM and readback port for the convolution-unit output stream (optional corner counter: HARRIS_COUNT_EN).
// Latency: a stream word is written on the edge it is sampled; readback data is registered one cycle after rd_addr.
// Backpressure: none; stream words arriving while a frame is held are dropped and flagged on o_overflow.
module mask_result_collector #(
    parameter int N          = 8,
    parameter int bitSize    = 6,
    parameter int pixelWidth = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_write_out_en,
    input  logic [bitSize:0]      i_stream_addr,
    input  logic [pixelWidth-1:0] i_stream_data,
    input  logic                  i_stream_harris,
    input  logic [bitSize:0]      i_rd_addr,
    output logic [pixelWidth-1:0] o_rd_data,
    output logic                  o_rd_harris,
    output logic                  o_frame_valid,
    input  logic                  i_frame_ack,
    output logic                  o_overflow,
    output logic                  o_addr_err,
    output logic [bitSize+1:0]    o_pix_count
`ifdef HARRIS_COUNT_EN
    ,
    output logic [bitSize+1:0]    o_corner_count
`endif
);

    localparam int AW    = bitSize + 1;
    localparam int CW    = bitSize + 2;
    localparam int DEPTH = N * N;
    localparam int IDX_W = $clog2(DEPTH);

    // Frame size widened by one bit so the bound itself is representable.
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Frame storage; never cleared, contents only meaningful while a frame is held.
    logic [pixelWidth-1:0] r_mem  [0:DEPTH-1];
    logic                  r_hmem [0:DEPTH-1];

    logic [pixelWidth-1:0] r_rd_data;
    logic                  r_rd_harris;
    logic                  r_overflow;
    logic                  r_addr_err;
    logic [CW-1:0]         r_pix_count;
    logic [AW-1:0]         r_last_addr;
    logic                  r_last_vld;

    logic                  w_accept;     // word belongs to the frame being captured
    logic                  w_start;      // word is the first of a new frame
    logic                  w_drop;       // word arrived while a frame is held
    logic                  w_frame_valid;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_wr_en;
    logic                  w_new_pix;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [IDX_W-1:0]      w_rd_idx;

    assign w_wr_ok  = ({1'b0, i_stream_addr} < DEPTH_W);
    assign w_rd_ok  = ({1'b0, i_rd_addr} < DEPTH_W);
    assign w_wr_idx = i_stream_addr[IDX_W-1:0];
    assign w_rd_idx = i_rd_addr[IDX_W-1:0];

    // A reset in the same cycle abandons the word, so it never reaches the RAM.
    assign w_wr_en  = w_accept && w_wr_ok && !i_rst;

    // The source repeats each word for two cycles; only an address change counts as a new pixel.
    assign w_new_pix = w_accept && w_wr_ok &&
                       (w_start || !r_last_vld || (i_stream_addr != r_last_addr));

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: ack in HOLD takes priority over the stream and may start a new frame directly.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_write_out_en) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (!i_write_out_en) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (i_frame_ack) begin
                    w_state_nxt = i_write_out_en ? S_CAPTURE : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM outputs: which stream words are taken, which open a frame, which are dropped.
    always_comb begin
        w_accept      = 1'b0;
        w_start       = 1'b0;
        w_drop        = 1'b0;
        w_frame_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = i_write_out_en;
                w_start  = i_write_out_en;
            end
            S_CAPTURE: begin
                w_accept = i_write_out_en;
            end
            S_HOLD: begin
                w_frame_valid = 1'b1;
                w_accept      = i_write_out_en && i_frame_ack;
                w_start       = i_write_out_en && i_frame_ack;
                w_drop        = i_write_out_en && !i_frame_ack;
            end
            default: begin
                w_accept = 1'b0;
            end
        endcase
    end

    // Frame RAM write port; no reset so it maps onto plain memory.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx]  <= i_stream_data;
            r_hmem[w_wr_idx] <= i_stream_harris;
        end
    end

    // Registered readback; old data is returned when the same address is written this cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data   <= '0;
            r_rd_harris <= 1'b0;
        end else if (w_rd_ok) begin
            r_rd_data   <= r_mem[w_rd_idx];
            r_rd_harris <= r_hmem[w_rd_idx];
        end else begin
            r_rd_data   <= '0;
            r_rd_harris <= 1'b0;
        end
    end

    // Pixel counter and last-address tracker; both restart on the first word of a frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pix_count <= '0;
            r_last_addr <= '0;
            r_last_vld  <= 1'b0;
        end else if (w_accept) begin
            if (w_start) begin
                r_pix_count <= w_new_pix ? CNT_ONE : '0;
            end else if (w_new_pix) begin
                r_pix_count <= r_pix_count + CNT_ONE;
            end
            if (w_wr_ok) begin
                r_last_addr <= i_stream_addr;
                r_last_vld  <= 1'b1;
            end else if (w_start) begin
                r_last_vld  <= 1'b0;
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (i_write_out_en && !w_wr_ok) begin
                r_addr_err <= 1'b1;
            end
        end
    end

`ifdef HARRIS_COUNT_EN
    logic [CW-1:0] r_corner_count;

    // Corner counter follows the pixel counter: only newly counted pixels contribute.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_corner_count <= '0;
        end else if (w_accept) begin
            if (w_start) begin
                r_corner_count <= (w_new_pix && i_stream_harris) ? CNT_ONE : '0;
            end else if (w_new_pix && i_stream_harris) begin
                r_corner_count <= r_corner_count + CNT_ONE;
            end
        end
    end

    assign o_corner_count = r_corner_count;
`endif

    assign o_rd_data     = r_rd_data;
    assign o_rd_harris   = r_rd_harris;
    assign o_frame_valid = w_frame_valid;
    assign o_overflow    = r_overflow;
    assign o_addr_err    = r_addr_err;
    assign o_pix_count   = r_pix_count;

endmodule

// File: tb/tb_mask_result_collector.sv
// Bench for mask_result_collector: directed scenarios plus randomized stream checked against a frame-level model.
// Each step drives inputs, waits one rising edge, updates the model, then samples outputs 1ns later.
// The model tracks held/capturing frame status, RAM image, counts and sticky flags per cycle.
module tb_mask_result_collector;

    localparam int N     = 8;
    localparam int BS    = 6;
    localparam int PW    = 8;
    localparam int DEPTH = N * N;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_write_out_en;
    logic [BS:0]   i_stream_addr;
    logic [PW-1:0] i_stream_data;
    logic          i_stream_harris;
    logic [BS:0]   i_rd_addr;
    logic [PW-1:0] o_rd_data;
    logic          o_rd_harris;
    logic          o_frame_valid;
    logic          i_frame_ack;
    logic          o_overflow;
    logic          o_addr_err;
    logic [BS+1:0] o_pix_count;
`ifdef HARRIS_COUNT_EN
    logic [BS+1:0] o_corner_count;
`endif

    always #5 i_clk = ~i_clk;

    mask_result_collector #(.N(N), .bitSize(BS), .pixelWidth(PW)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_write_out_en  (i_write_out_en),
        .i_stream_addr   (i_stream_addr),
        .i_stream_data   (i_stream_data),
        .i_stream_harris (i_stream_harris),
        .i_rd_addr       (i_rd_addr),
        .o_rd_data       (o_rd_data),
        .o_rd_harris     (o_rd_harris),
        .o_frame_valid   (o_frame_valid),
        .i_frame_ack     (i_frame_ack),
        .o_overflow      (o_overflow),
        .o_addr_err      (o_addr_err),
        .o_pix_count     (o_pix_count)
`ifdef HARRIS_COUNT_EN
        ,
        .o_corner_count  (o_corner_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [PW-1:0] m_mem   [DEPTH];
    logic          m_hm    [DEPTH];
    bit            m_known [DEPTH];
    bit            m_busy, m_held, m_ovf, m_aerr, m_last_vld;
    int            m_pix, m_corners, m_last;
    logic [PW-1:0] m_rd;
    logic          m_rdh;
    bit            m_rd_known;

    task automatic step(input logic en, input int a, input logic [PW-1:0] d, input logic h,
                        input logic ack, input int ra, input logic rst);
        bit acc;
        i_write_out_en  = en;
        i_stream_addr   = 7'(a);
        i_stream_data   = d;
        i_stream_harris = h;
        i_frame_ack     = ack;
        i_rd_addr       = 7'(ra);
        i_rst           = rst;
        @(posedge i_clk);
        if (rst) begin
            m_busy = 0; m_held = 0; m_ovf = 0; m_aerr = 0; m_last_vld = 0;
            m_pix = 0; m_corners = 0; m_last = 0;
            m_rd = '0; m_rdh = 1'b0; m_rd_known = 1;
        end else begin
            if (ra < DEPTH) begin
                m_rd_known = m_known[ra]; m_rd = m_mem[ra]; m_rdh = m_hm[ra];
            end else begin
                m_rd_known = 1; m_rd = '0; m_rdh = 1'b0;
            end
            if (en && a >= DEPTH) m_aerr = 1;
            acc = en && (!m_held || ack);
            if (m_held && en && !ack) m_ovf = 1;
            if (acc) begin
                if (!m_busy) begin
                    m_pix = 0; m_corners = 0; m_last_vld = 0;
                end
                if (a < DEPTH) begin
                    m_mem[a] = d; m_hm[a] = h; m_known[a] = 1;
                    if (!m_last_vld || a != m_last) begin
                        m_pix++;
                        if (h) m_corners++;
                    end
                    m_last = a; m_last_vld = 1;
                end
                m_busy = 1; m_held = 0;
            end else if (m_busy) begin
                m_busy = 0; m_held = 1;
            end else if (m_held && ack) begin
                m_held = 0;
            end
        end
        #1;
    endtask

    // One source word, repeated for two cycles as the convolution unit does.
    task automatic send_word(input int a, input logic [PW-1:0] d, input logic h, input int ra);
        step(1'b1, a, d, h, 1'b0, ra, 1'b0);
        step(1'b1, a, d, h, 1'b0, ra, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 0, '0, 1'b0, 1'b0, 0, 1'b1);
        step(1'b0, 0, '0, 1'b0, 1'b0, 0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid got %b want 0", o_frame_valid); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", o_overflow); end
        checks++; if (o_addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err got %b want 0", o_addr_err); end
        checks++; if (o_pix_count !== 8'd0) begin errors++; $display("FAIL reset_pix_count got %0d want 0", o_pix_count); end
        checks++; if (o_rd_data !== 8'd0) begin errors++; $display("FAIL reset_rd_data got %0h want 0", o_rd_data); end
        checks++; if (o_rd_harris !== 1'b0) begin errors++; $display("FAIL reset_rd_harris got %b want 0", o_rd_harris); end
    endtask

    task automatic test_basic_frame();
        for (int a = 0; a < 63; a++) send_word(a, 8'(a), (a == 27), 0);
        checks++; if (o_frame_valid !== 1'b0) begin errors++; $display("FAIL capture_frame_valid got %b want 0", o_frame_valid); end
        step(1'b0, 0, '0, 1'b0, 1'b0, 27, 1'b0);
        checks++; if (o_frame_valid !== 1'b1) begin errors++; $display("FAIL frame_valid_after_drop got %b want 1", o_frame_valid); end
        checks++; if (o_pix_count !== 8'd63) begin errors++; $display("FAIL frame_pix_count got %0d want 63", o_pix_count); end
        step(1'b0, 0, '0, 1'b0, 1'b0, 27, 1'b0);
        checks++; if (o_rd_data !== 8'd27) begin errors++; $display("FAIL rd27_data got %0d want 27", o_rd_data); end
        checks++; if (o_rd_harris !== 1'b1) begin errors++; $display("FAIL rd27_harris got %b want 1", o_rd_harris); end
        step(1'b0, 0, '0, 1'b0, 1'b0, 26, 1'b0);
        checks++; if (o_rd_harris !== 1'b0) begin errors++; $display("FAIL rd26_harris got %b want 0", o_rd_harris); end
`ifdef HARRIS_COUNT_EN
        checks++; if (o_corner_count !== 8'd1) begin errors++; $display("FAIL frame_corner_count got %0d want 1", o_corner_count); end
`endif
    endtask

    task automatic test_overflow();
        step(1'b1, 5, 8'hAA, 1'b0, 1'b0, 5, 1'b0);
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got %b want 1", o_overflow); end
        checks++; if (o_frame_valid !== 1'b1) begin errors++; $display("FAIL overflow_still_held got %b want 1", o_frame_valid); end
        step(1'b0, 0, '0, 1'b0, 1'b0, 5, 1'b0);
        checks++; if (o_rd_data !== 8'd5) begin errors++; $display("FAIL overflow_rd5 got %0h want 05", o_rd_data); end
        checks++; if (o_pix_count !== 8'd63) begin errors++; $display("FAIL overflow_pix_count got %0d want 63", o_pix_count); end
    endtask

    task automatic test_ack_with_write();
        do_reset();
        for (int a = 0; a < 4; a++) send_word(a, 8'(8'h40 + a), 1'b0, 0);
        step(1'b0, 0, '0, 1'b0, 1'b0, 0, 1'b0);
        checks++; if (o_frame_valid !== 1'b1) begin errors++; $display("FAIL small_frame_valid got %b want 1", o_frame_valid); end
        step(1'b1, 0, 8'h11, 1'b0, 1'b1, 0, 1'b0);
        checks++; if (o_frame_valid !== 1'b0) begin errors++; $display("FAIL ack_frame_valid got %b want 0", o_frame_valid); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ack_overflow got %b want 0", o_overflow); end
        checks++; if (o_rd_data !== 8'h40) begin errors++; $display("FAIL read_before_write got %0h want 40", o_rd_data); end
        step(1'b0, 0, '0, 1'b0, 1'b0, 0, 1'b0);
        checks++; if (o_rd_data !== 8'h11) begin errors++; $display("FAIL ack_write_mem0 got %0h want 11", o_rd_data); end
        checks++; if (o_pix_count !== 8'd1) begin errors++; $display("FAIL ack_pix_count got %0d want 1", o_pix_count); end
        checks++; if (o_frame_valid !== 1'b1) begin errors++; $display("FAIL ack_new_frame_valid got %b want 1", o_frame_valid); end
        step(1'b0, 0, '0, 1'b0, 1'b1, 0, 1'b0);
        step(1'b0, 0, '0, 1'b0, 1'b1, 0, 1'b0);
        checks++; if (o_pix_count !== 8'd1) begin errors++; $display("FAIL pix_kept_after_ack got %0d want 1", o_pix_count); end
    endtask

    task automatic test_addr_err();
        do_reset();
        send_word(0, 8'hC0, 1'b0, 0);
        send_word(1, 8'hC1, 1'b0, 0);
        send_word(63, 8'hC3, 1'b1, 0);
        send_word(64, 8'hEE, 1'b1, 0);
        checks++; if (o_addr_err !== 1'b1) begin errors++; $display("FAIL addr_err_set got %b want 1", o_addr_err); end
        checks++; if (o_pix_count !== 8'd3) begin errors++; $display("FAIL addr_err_pix got %0d want 3", o_pix_count); end
        step(1'b0, 0, '0, 1'b0, 1'b0, 64, 1'b0);
        checks++; if (o_frame_valid !== 1'b1) begin errors++; $display("FAIL addr_err_frame_valid got %b want 1", o_frame_valid); end
        checks++; if (o_rd_data !== 8'd0) begin errors++; $display("FAIL rd64_data got %0h want 0", o_rd_data); end
        step(1'b0, 0, '0, 1'b0, 1'b0, 63, 1'b0);
        checks++; if (o_rd_data !== 8'hC3) begin errors++; $display("FAIL rd63_data got %0h want c3", o_rd_data); end
        step(1'b0, 0, '0, 1'b0, 1'b0, 0, 1'b0);
        checks++; if (o_rd_data !== 8'hC0) begin errors++; $display("FAIL rd0_untouched got %0h want c0", o_rd_data); end
    endtask

    task automatic test_rst_mid_frame();
        do_reset();
        for (int a = 0; a < 10; a++) send_word(a, 8'(a), 1'b0, 0);
        step(1'b1, 10, 8'd10, 1'b0, 1'b0, 0, 1'b1);
        checks++; if (o_pix_count !== 8'd0) begin errors++; $display("FAIL rst_mid_pix got %0d want 0", o_pix_count); end
        step(1'b0, 0, '0, 1'b0, 1'b0, 0, 1'b0);
        checks++; if (o_frame_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_frame_valid got %b want 0", o_frame_valid); end
        for (int a = 0; a < 63; a++) send_word(a, 8'(a) ^ 8'h5A, (a % 9 == 0), 0);
        step(1'b0, 0, '0, 1'b0, 1'b0, 40, 1'b0);
        checks++; if (o_frame_valid !== 1'b1) begin errors++; $display("FAIL refill_frame_valid got %b want 1", o_frame_valid); end
        checks++; if (o_pix_count !== 8'd63) begin errors++; $display("FAIL refill_pix got %0d want 63", o_pix_count); end
        for (int k = 0; k < 4; k++) begin
            int ra;
            ra = $urandom_range(0, 62);
            step(1'b0, 0, '0, 1'b0, 1'b0, ra, 1'b0);
            checks++; if (o_rd_data !== (8'(ra) ^ 8'h5A)) begin errors++; $display("FAIL refill_rd addr %0d got %0h want %0h", ra, o_rd_data, 8'(ra) ^ 8'h5A); end
        end
    endtask

`ifdef HARRIS_COUNT_EN
    task automatic test_harris_count();
        do_reset();
        send_word(3, 8'h03, 1'b1, 0);
        send_word(4, 8'h04, 1'b0, 0);
        send_word(10, 8'h0A, 1'b1, 0);
        send_word(20, 8'h14, 1'b1, 0);
        step(1'b0, 0, '0, 1'b0, 1'b0, 0, 1'b0);
        checks++; if (o_corner_count !== 8'd3) begin errors++; $display("FAIL corner_count got %0d want 3", o_corner_count); end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int w = 0; w < 300; w++) begin
            logic en, h, ack;
            int a, ra, hold;
            logic [PW-1:0] d;
            en   = ($urandom_range(0, 3) != 0);
            a    = $urandom_range(0, 70);
            d    = 8'($urandom);
            h    = 1'($urandom);
            ack  = ($urandom_range(0, 4) == 0);
            ra   = $urandom_range(0, 66);
            hold = $urandom_range(1, 2);
            for (int c = 0; c < hold; c++) begin
                step(en, a, d, h, ack, ra, 1'b0);
                checks++; if (o_frame_valid !== m_held) begin errors++; $display("FAIL rand_frame_valid w%0d got %b want %b", w, o_frame_valid, m_held); end
                checks++; if (o_pix_count !== 8'(m_pix)) begin errors++; $display("FAIL rand_pix w%0d got %0d want %0d", w, o_pix_count, m_pix); end
                checks++; if (o_overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow w%0d got %b want %b", w, o_overflow, m_ovf); end
                checks++; if (o_addr_err !== m_aerr) begin errors++; $display("FAIL rand_addr_err w%0d got %b want %b", w, o_addr_err, m_aerr); end
                if (m_rd_known) begin
                    checks++; if (o_rd_data !== m_rd) begin errors++; $display("FAIL rand_rd_data w%0d addr %0d got %0h want %0h", w, ra, o_rd_data, m_rd); end
                    checks++; if (o_rd_harris !== m_rdh) begin errors++; $display("FAIL rand_rd_harris w%0d addr %0d got %b want %b", w, ra, o_rd_harris, m_rdh); end
                end
`ifdef HARRIS_COUNT_EN
                checks++; if (o_corner_count !== 8'(m_corners)) begin errors++; $display("FAIL rand_corners w%0d got %0d want %0d", w, o_corner_count, m_corners); end
`endif
            end
        end
    endtask

    initial begin
        i_rst = 1'b1; i_write_out_en = 1'b0; i_stream_addr = '0; i_stream_data = '0;
        i_stream_harris = 1'b0; i_rd_addr = '0; i_frame_ack = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
        test_reset();
        test_basic_frame();
        test_overflow();
        test_ack_with_write();
        test_addr_err();
        test_rst_mid_frame();
`ifdef HARRIS_COUNT_EN
        test_harris_count();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
